// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Imported by the transmitter (top) and the receiver.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first shifter.
// Framing errors park in STOP until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HLAST = CW'(DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BLAST = BIT_W'(DATA_W - 1);

  logic              s1_q, s2_q;
  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  // Sync flops reset to the idle level so reset release is not a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!s2_q) state_d = START;
      end
      START: begin
        if (cnt_q == HLAST) begin
          cnt_d   = '0;
          state_d = s2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[DATA_W-1:1]};
          if (bit_q == BLAST) state_d = STOP;
          else bit_d = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (ferr_q) begin
          if (s2_q) begin
            ferr_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (s2_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART; transmitter inline, receiver in uart_rx.
// tx is registered from the current TX state, so it lags the state by one clock.
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [BIT_W-1:0] BLAST = BIT_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              cnt_end;

  assign cnt_end = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (data_valid) begin
          sh_d    = data_in;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        tx_d = sh_q[0];
        if (cnt_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == BLAST) state_d = STOP;
          else bit_d = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx = tx_q;

  uart_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk_i   (clk),
    .rst_i   (rst),
    .rx_i    (rx),
    .data_o  (data_out),
    .valid_o (data_ready)
  );

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for uart, scaled to 16 clocks per bit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart;

  localparam int BAUD = 1000000;
  localparam int CLKF = 16000000;
  localparam int DIV  = CLKF / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_ready;

  int total = 0;
  int bad = 0;
  int rdy_cnt = 0;

  uart #(
    .BAUD_RATE  (BAUD),
    .CLOCK_FREQ (CLKF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_out   (data_out),
    .data_ready (data_ready)
  );

  always #5 clk = ~clk;

  // Counts clocks with data_ready high; one per good frame.
  always @(negedge clk) if (data_ready === 1'b1) rdy_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at a falling edge; returns at the falling edge in the first IDLE cycle.
  task automatic tx_send(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    data_in = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("tx_hold", {31'd0, tx}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      logic [DIV-1:0] seen;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        seen[c] = tx;
      end
      chk($sformatf("tx_%02h_bit%0d", b, k), 32'(seen), 32'({DIV{fr[k]}}));
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic tx_quiet(input string tag, input int n);
    logic hi;
    hi = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hi = hi & tx;
    end
    chk(tag, {31'd0, hi}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_dout", {24'd0, data_out}, 32'h00);
    chk("rst_rdy", {31'd0, data_ready}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_send(8'hA5);
    tx_quiet("tx_idle_a5", 2 * DIV);

    rx_send(8'h5A, 1'b1);
    repeat (DIV) @(negedge clk);
    chk("rx_5a_rdy", 32'(rdy_cnt), 32'd1);
    chk("rx_5a_dout", {24'd0, data_out}, 32'h5A);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("glitch_rdy", 32'(rdy_cnt), 32'd1);
    chk("glitch_dout", {24'd0, data_out}, 32'h5A);

    rx_send(8'h3C, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    chk("ferr_rdy", 32'(rdy_cnt), 32'd1);
    chk("ferr_dout", {24'd0, data_out}, 32'h5A);
    rx_send(8'hC3, 1'b1);
    repeat (DIV) @(negedge clk);
    chk("rx_c3_rdy", 32'(rdy_cnt), 32'd2);
    chk("rx_c3_dout", {24'd0, data_out}, 32'hC3);

    fork
      tx_send(8'hA5);
      begin
        repeat (3 * DIV) @(negedge clk);
        data_in = 8'h11;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
      end
    join
    tx_quiet("tx_no_11", 3 * DIV);

    tx_send(8'h96);
    tx_send(8'h0F);
    tx_quiet("tx_idle_b2b", DIV);

    data_in = 8'hA5;
    data_valid = 1'b1;
    rx = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", {31'd0, tx}, 32'd1);
    chk("arst_rdy", {31'd0, data_ready}, 32'd0);
    chk("arst_dout", {24'd0, data_out}, 32'h00);
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_quiet("post_rst_tx", 12 * DIV);
    chk("post_rst_rdy", 32'(rdy_cnt), 32'd2);
    chk("post_rst_dout", {24'd0, data_out}, 32'h00);

    tx_send(8'hA5);
    rx_send(8'h5A, 1'b1);
    repeat (DIV) @(negedge clk);
    chk("rx2_5a_rdy", 32'(rdy_cnt), 32'd3);
    chk("rx2_5a_dout", {24'd0, data_out}, 32'h5A);

    fork
      tx_send(8'h3C);
      rx_send(8'hA5, 1'b1);
    join
    repeat (DIV) @(negedge clk);
    chk("dup_rdy", 32'(rdy_cnt), 32'd4);
    chk("dup_dout", {24'd0, data_out}, 32'hA5);
    tx_quiet("dup_tx_idle", DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
